// File: rtl/fnd_scan_decoder.sv
// rtl/fnd_scan_decoder.sv - samples a multiplexed 4-digit 7-segment bus and rebuilds BCD frames
// Define FND_SCAN_DECODER_DP_EN to capture decimal points (fnd_data[7]) per digit.
module fnd_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  fnd_com,
  input  logic [7:0]  fnd_data,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stalled
);

`ifdef FND_SCAN_DECODER_DP_EN
  localparam int DW = 8;
`else
  localparam int DW = 7;
`endif
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, STALL} state_t;

  state_t          state;
  state_t          next_state;
  logic [3:0]      s_com;
  logic [DW-1:0]   s_data;
  logic [3:0]      p_com;
  logic [DW-1:0]   p_data;
  logic [SW-1:0]   stab_cnt;
  logic [TW-1:0]   tcnt;
  logic [3:0]      seen;
  logic            err;
  logic [3:0]      slot_nib [4];
  logic            same;
  logic            capture;
  logic            com_legal;
  logic            com_blank;
  logic [1:0]      idx;
  logic [3:0]      sel;
  logic [4:0]      seg_dec;
  logic            legal_cap;
  logic            illegal_cap;
  logic            frame_done;
  logic [15:0]     frame_nib;

  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   return {1'b0, 4'd0};
      7'h79:   return {1'b0, 4'd1};
      7'h24:   return {1'b0, 4'd2};
      7'h30:   return {1'b0, 4'd3};
      7'h19:   return {1'b0, 4'd4};
      7'h12:   return {1'b0, 4'd5};
      7'h02:   return {1'b0, 4'd6};
      7'h78:   return {1'b0, 4'd7};
      7'h00:   return {1'b0, 4'd8};
      7'h10:   return {1'b0, 4'd9};
      7'h7F:   return {1'b0, 4'hF};
      default: return {1'b1, 4'hE};
    endcase
  endfunction

  always_comb begin
    com_legal = 1'b1;
    idx       = 2'd0;
    case (s_com)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: com_legal = 1'b0;
    endcase
  end

  assign com_blank   = (s_com == 4'hF);
  assign sel         = ~s_com;
  assign seg_dec     = seg_decode(s_data[6:0]);
  assign same        = (s_com == p_com) && (s_data == p_data);
  // Fires only on the edge the counter steps into saturation, so a held value captures once.
  assign capture     = enable && (state != IDLE) && same && (stab_cnt == SETTLE_LAST);
  assign legal_cap   = capture && com_legal;
  assign illegal_cap = capture && !com_legal && !com_blank;
  assign frame_done  = legal_cap && ((seen | sel) == 4'hF);

  always_comb begin
    frame_nib = {slot_nib[3], slot_nib[2], slot_nib[1], slot_nib[0]};
    frame_nib[{idx, 2'b00} +: 4] = seg_dec[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = SCAN;
        SCAN:    if (!legal_cap && tcnt == TIMEOUT_LAST) next_state = STALL;
        STALL:   if (legal_cap) next_state = SCAN;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    stalled = (state == STALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_com       <= 4'hF;
      s_data      <= '1;
      p_com       <= 4'hF;
      p_data      <= '1;
      stab_cnt    <= '0;
      tcnt        <= '0;
      seen        <= 4'h0;
      err         <= 1'b0;
      digits      <= 16'h0000;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      for (int i = 0; i < 4; i++) slot_nib[i] <= 4'h0;
    end else begin
      s_com       <= fnd_com;
      s_data      <= fnd_data[DW-1:0];
      p_com       <= s_com;
      p_data      <= s_data;
      frame_valid <= 1'b0;
      if (!enable || state == IDLE) begin
        stab_cnt <= '0;
        tcnt     <= '0;
        seen     <= 4'h0;
        err      <= 1'b0;
      end else begin
        if (!same) begin
          stab_cnt <= '0;
        end else if (stab_cnt != SETTLE_MAX) begin
          stab_cnt <= stab_cnt + 1'b1;
        end

        // Blanking intervals keep counting toward the stall timeout.
        if (legal_cap) begin
          tcnt <= '0;
        end else if (state == SCAN && tcnt != TIMEOUT_MAX) begin
          tcnt <= tcnt + 1'b1;
        end

        if (state == SCAN && next_state == STALL) begin
          seen <= 4'h0;
        end else if (legal_cap) begin
          slot_nib[idx] <= seg_dec[3:0];
          if (frame_done) begin
            digits      <= frame_nib;
            frame_err   <= err | seg_dec[4];
            frame_valid <= 1'b1;
            seen        <= 4'h0;
            err         <= 1'b0;
          end else begin
            seen <= seen | sel;
            err  <= err | seg_dec[4];
          end
        end else if (illegal_cap) begin
          err <= 1'b1;
        end
      end
    end
  end

`ifdef FND_SCAN_DECODER_DP_EN
  logic [3:0] slot_dp;
  logic [3:0] frame_dp;

  always_comb begin
    frame_dp      = slot_dp;
    frame_dp[idx] = ~s_data[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_dp <= 4'h0;
      dp      <= 4'h0;
    end else if (enable && legal_cap && state != IDLE) begin
      slot_dp[idx] <= ~s_data[7];
      if (frame_done) dp <= frame_dp;
    end
  end
`else
  logic unused_dp_bit;
  assign unused_dp_bit = fnd_data[7];
  assign dp            = 4'h0;
`endif

endmodule
